// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbiter for the shared uio pad bus, with hold limit and turnaround gap.
// Ports: clk, rst_n, ena, req/dir/wdata[/lock], gnt, uio_in/out/oe, rdata/rdata_vld, busy. Option: UIO_ARB_LOCK_EN.
module uio_bus_arbiter #(
  parameter int         NREQ        = 4,
  parameter int         MAX_HOLD    = 8,
  parameter int         TURN_CYCLES = 1,
  parameter logic [7:0] OE_MASK     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
`ifdef UIO_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [7:0]        rdata,
  output logic              rdata_vld,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt_ptr;
  logic [PW:0]   idx;
  logic          found;
  logic [7:0]    hold;
  logic [1:0]    turn_cnt;
  logic          dir_q;
  logic          other_req;
  logic          owner_lock;
  logic          hold_max;
  logic          rel;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign nxt_ptr = (win == PW'(NREQ-1)) ? '0
                 : win + 1'b1;

`ifdef UIO_ARB_LOCK_EN
  assign owner_lock = lock[owner];
`else
  assign owner_lock = 1'b0;
`endif

  assign other_req = |(req & ~gnt);
  assign hold_max  = (hold == 8'(MAX_HOLD));
  assign rel = !req[owner]
            || (hold_max && other_req
                && !owner_lock);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      hold      <= '0;
      turn_cnt  <= '0;
      dir_q     <= 1'b0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
    end else if (!ena) begin
      state     <= IDLE;
      gnt       <= '0;
      hold      <= '0;
      turn_cnt  <= '0;
      rdata_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rdata_vld <= 1'b0;
          if (found) begin
            state  <= GRANT;
            gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            owner  <= win;
            dir_q  <= dir[win];
            hold   <= 8'd1;
            rr_ptr <= nxt_ptr;
          end
        end
        GRANT: begin
          if (!dir_q) begin
            rdata     <= uio_in;
            rdata_vld <= 1'b1;
          end else begin
            rdata_vld <= 1'b0;
          end
          if (rel) begin
            gnt  <= '0;
            hold <= '0;
            if (dir_q && TURN_CYCLES > 0) begin
              state    <= TURN;
              turn_cnt <= 2'd1;
            end else begin
              state <= IDLE;
            end
          end else if (!hold_max) begin
            hold <= hold + 8'd1;
          end
        end
        TURN: begin
          rdata_vld <= 1'b0;
          if (turn_cnt >= 2'(TURN_CYCLES))
            state <= IDLE;
          else
            turn_cnt <= turn_cnt + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pad drive follows the registered grant, so it drops at the release edge.
  logic drive;
  assign drive   = (state == GRANT) && dir_q;
  assign uio_oe  = drive ? OE_MASK : 8'h00;
  assign uio_out = drive ? wdata[{owner, 3'b000} +: 8]
                 : 8'h00;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter.
// Scoreboard queues hold expected read data and grant order.
module tb_uio_bus_arbiter;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] dir;
  logic [31:0]     wdata;
`ifdef UIO_ARB_LOCK_EN
  logic [NREQ-1:0] lock;
`endif
  logic [NREQ-1:0] gnt;
  logic [7:0]      uio_in;
  logic [7:0]      uio_out;
  logic [7:0]      uio_oe;
  logic [7:0]      rdata;
  logic            rdata_vld;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int         own_q[$];

  uio_bus_arbiter #(
    .NREQ(4), .MAX_HOLD(8),
    .TURN_CYCLES(1), .OE_MASK(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .req(req),
    .dir(dir),
    .wdata(wdata),
`ifdef UIO_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .rdata(rdata),
    .rdata_vld(rdata_vld),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]      v;
    logic [NREQ-1:0] prev;
    int              len;
    int              gap;
    int              cur_own;
    bit              seen;

    req = '0;
    dir = '0;
    wdata = '0;
    uio_in = '0;
`ifdef UIO_ARB_LOCK_EN
    lock = '0;
`endif
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_oe", uio_oe, 0);
    check("rst_out", uio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_vld", rdata_vld, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    // single writer
    wdata[23:16] = 8'hA5;
    dir = 4'b0100;
    req = 4'b0100;
    tick();
    check("wr_gnt", gnt, 4'b0100);
    check("wr_oe", uio_oe, 8'hFF);
    check("wr_out", uio_out, 8'hA5);
    check("wr_busy", busy, 1);
    tick();
    tick();
    check("wr_gnt_hold", gnt, 4'b0100);
    req = '0;
    tick();
    check("wr_rel_gnt", gnt, 0);
    check("wr_rel_oe", uio_oe, 0);
    check("wr_turn_busy", busy, 1);
    tick();
    check("wr_idle_busy", busy, 0);

    // reader
    dir = '0;
    req = 4'b0001;
    tick();
    check("rd_gnt", gnt, 4'b0001);
    check("rd_oe", uio_oe, 0);
    check("rd_out", uio_out, 0);
    for (int k = 0; k < 6; k++) begin
      v = 8'($urandom);
      if (k == 0) v = 8'h3C;
      uio_in = v;
      exp_q.push_back(v);
      tick();
      check("rd_vld", rdata_vld, 1);
      check("rd_data", rdata, exp_q.pop_front());
    end
    req = '0;
    tick();
    tick();
    check("rd_end_vld", rdata_vld, 0);
    check("rd_end_busy", busy, 0);

    // asynchronous reset during a write grant
    wdata[31:24] = 8'h5A;
    dir = 4'b1000;
    req = 4'b1000;
    tick();
    check("ar_gnt", gnt, 4'b1000);
    check("ar_out", uio_out, 8'h5A);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt0", gnt, 0);
    check("ar_oe0", uio_oe, 0);
    check("ar_out0", uio_out, 0);
    check("ar_busy0", busy, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // round robin among four writers
    dir = 4'b1111;
    wdata = 32'hD3C2B1A0;
    own_q = '{0, 1, 2, 3, 0, 1};
    req = 4'b1111;
    prev = '0;
    len = 0;
    gap = 0;
    cur_own = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      check("rr_onehot",
            32'($countones(gnt) <= 1), 1);
      if (gnt != 0) begin
        if (prev == 0) begin
          if (seen)
            check("rr_gap", 32'(gap >= 2), 1);
          if (own_q.size() > 0) begin
            cur_own = own_q.pop_front();
            check("rr_owner", gnt,
                  32'(1) << cur_own);
          end else begin
            check("rr_extra", gnt, 0);
          end
          len = 0;
          gap = 0;
          seen = 1'b1;
        end
        len++;
        check("rr_out", uio_out,
              wdata[8*cur_own +: 8]);
      end else begin
        if (prev != 0)
          check("rr_len", len, 8);
        if (uio_oe == 0) gap++;
      end
      prev = gnt;
    end
    check("rr_pending", own_q.size(), 0);
    req = '0;
    tick();
    tick();
    tick();

    // lone requester holds past MAX_HOLD
    dir = 4'b0010;
    req = 4'b0010;
    tick();
    for (int i = 0; i < 40; i++) begin
      check("sat_gnt", gnt, 4'b0010);
      tick();
    end
    req = '0;
    tick();
    tick();
    tick();
    check("sat_idle", busy, 0);

    // ena low drops a writer without TURN
    dir = 4'b0001;
    req = 4'b0001;
    tick();
    check("ena_gnt", gnt, 4'b0001);
    check("ena_oe", uio_oe, 8'hFF);
    ena = 1'b0;
    tick();
    check("ena_gnt0", gnt, 0);
    check("ena_oe0", uio_oe, 0);
    check("ena_busy0", busy, 0);
    req = '0;
    ena = 1'b1;
    tick();

`ifdef UIO_ARB_LOCK_EN
    dir = '0;
    req = 4'b0001;
    tick();
    check("lk_gnt", gnt, 4'b0001);
    lock = 4'b0001;
    req = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("lk_keep", gnt, 4'b0001);
    end
    req = 4'b1000;
    tick();
    check("lk_rel", gnt, 0);
    tick();
    check("lk_next", gnt, 4'b1000);
    req = '0;
    lock = '0;
    tick();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
